// File: rtl/ext_shift_unit.sv
// -----------------------------------------------------------------------------
// ext_shift_unit
//
// Immediate extender followed by an iterative shifter. An IN_W-bit field is
// extended to OUT_W bits (zero, sign, upper-placement or ones-fill) and then
// optionally shifted left, logical-right or arithmetic-right by a run-time
// amount, STEP bits per clock. One registered result, start/done handshake.
//
// Parameters
//   IN_W     width of the input field (1 <= IN_W <= OUT_W)
//   OUT_W    result width
//   SHAMT_W  shift-amount width, clog2(OUT_W)
//   STEP     bits shifted per clock (1 <= STEP <= OUT_W-1)
//
// Ports
//   clk       clock, all state on the rising edge
//   rst_n     synchronous active-low reset
//   start     request, sampled only while busy=0
//   in_data   field to extend
//   ext_mode  00 zero, 01 sign, 10 upper placement, 11 ones-fill
//   sh_op     00 none, 01 SLL, 10 SRL, 11 SRA
//   shamt     shift amount (ignored when sh_op=00)
//   busy      high while a shift is in progress
//   done      one-cycle pulse when out_data takes a new result
//   out_data  registered result, held until the next done
// -----------------------------------------------------------------------------
module ext_shift_unit #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IN_W-1:0]    in_data,
    input  logic [1:0]         ext_mode,
    input  logic [1:0]         sh_op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   out_data
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [OUT_W-1:0]   acc_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [1:0]         op_reg;
    logic [OUT_W-1:0]   out_reg;
    logic               done_reg;

    logic [OUT_W-1:0]   ext_value;
    logic [SHAMT_W-1:0] eff_n;
    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W-1:0] cnt_rem;
    logic [OUT_W-1:0]   shifted;

    logic load_direct;
    logic load_acc;
    logic finish;

    // -------------------------------------------------------------------------
    // Extension. With IN_W == OUT_W there is nothing to pad, so every mode
    // passes the field through unchanged.
    // -------------------------------------------------------------------------
    generate
        if (IN_W == OUT_W) begin : g_ext_pass
            logic unused_ext_mode;
            assign unused_ext_mode = ^ext_mode;
            always_comb begin
                ext_value = in_data;
            end
        end else begin : g_ext_pad
            localparam int PAD = OUT_W - IN_W;
            always_comb begin
                ext_value = {{PAD{1'b0}}, in_data};
                case (ext_mode)
                    2'b00:   ext_value = {{PAD{1'b0}}, in_data};
                    2'b01:   ext_value = {{PAD{in_data[IN_W-1]}}, in_data};
                    2'b10:   ext_value = {in_data, {PAD{1'b0}}};
                    default: ext_value = {{PAD{1'b1}}, in_data};
                endcase
            end
        end
    endgenerate

    // A request with no shift operation completes directly from IDLE.
    assign eff_n = (sh_op == OP_NONE) ? '0 : shamt;

    // -------------------------------------------------------------------------
    // One shift stage: move by min(STEP, remaining count). The last stage may
    // be shorter than STEP when the amount is not a multiple of it.
    // -------------------------------------------------------------------------
    always_comb begin
        step_amt = (cnt_reg < STEP_C) ? cnt_reg : STEP_C;
        cnt_rem  = cnt_reg - step_amt;
        shifted  = acc_reg;
        case (op_reg)
            OP_SLL:  shifted = acc_reg << step_amt;
            OP_SRL:  shifted = acc_reg >> step_amt;
            OP_SRA:  shifted = $unsigned($signed(acc_reg) >>> step_amt);
            default: shifted = acc_reg;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start && (eff_n != '0)) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_rem == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        load_direct = 1'b0;
        load_acc    = 1'b0;
        finish      = 1'b0;
        case (state_reg)
            IDLE: begin
                load_direct = start && (eff_n == '0);
                load_acc    = start && (eff_n != '0);
            end
            SHIFT: begin
                busy   = 1'b1;
                finish = (cnt_rem == '0);
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers. start is only honoured in IDLE, so a request that
    // arrives mid-shift cannot disturb acc/cnt/op.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            cnt_reg  <= '0;
            op_reg   <= OP_NONE;
            out_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= load_direct || finish;
            if (load_direct) begin
                out_reg <= ext_value;
            end
            if (load_acc) begin
                acc_reg <= ext_value;
                cnt_reg <= eff_n;
                op_reg  <= sh_op;
            end else if (state_reg == SHIFT) begin
                acc_reg <= shifted;
                cnt_reg <= cnt_rem;
            end
            if (finish) begin
                out_reg <= shifted;
            end
        end
    end

    assign done     = done_reg;
    assign out_data = out_reg;

endmodule

// File: doc/ext_shift_unit.md
# ext_shift_unit

Parametrised immediate extender with an iterative shifter for the multi-cycle datapath. Accepts an IN_W-bit field, extends it to OUT_W bits (zero, sign, upper-placement or ones-fill), then optionally shifts it left, logical-right or arithmetic-right by a run-time amount at STEP bits per clock. It sits between the instruction register and the ALU operand mux. It serves both immediate handling and the SLL/SRL/SRA instructions with one registered result and a start/done handshake.

## Interface
- IN_W, 16, width of input field; 1 <= IN_W <= OUT_W
- OUT_W, 32, result width
- SHAMT_W, 5, shift-amount width; must equal clog2(OUT_W), so the maximum shift is OUT_W-1
- STEP, 1, bits shifted per cycle; 1 <= STEP <= OUT_W-1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only when busy=0
- in_data  in  IN_W  field to extend
- ext_mode  in  2  00 zero-extend, 01 sign-extend (in_data[IN_W-1]), 10 upper: {in_data, (OUT_W-IN_W) zeros}, 11 ones-fill: {ones, in_data}
- sh_op  in  2  00 none, 01 SLL, 10 SRL, 11 SRA
- shamt  in  SHAMT_W  shift amount; ignored when sh_op=00
- busy  out  1  high while a shift is in progress
- done  out  1  one-cycle pulse when out_data takes a new result
- out_data  out  OUT_W  registered result; holds until the next done

## Operation
- FSM states: IDLE, SHIFT. Internal registers: acc[OUT_W], cnt[SHAMT_W], op latch[2].
- ext value = ext_mode applied to in_data; when IN_W==OUT_W, all modes yield in_data unchanged.
- IDLE with start=1: effective count n = (sh_op==00) ? 0 : shamt.
  - n==0: out_data <= ext value, done <= 1, remain in IDLE.
  - n>0: acc <= ext value, cnt <= n, latch sh_op, busy <= 1, go to SHIFT.
- SHIFT, each cycle: s = min(STEP, cnt).
  - SLL: acc << s. SRL: zero-fill right shift. SRA: right shift filling acc[OUT_W-1].
  - cnt <= cnt - s.
  - If cnt - s == 0: out_data <= shifted acc, done <= 1, busy <= 0, go to IDLE.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- Inputs are captured on the start edge only; later changes to in_data, modes or shamt have no effect.
- ext_mode, sh_op and shamt are fully decoded; there are no illegal encodings.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, busy=0, done=0, out_data=0, acc=0, cnt=0.
- Reset mid-shift aborts the operation: no done pulse, out_data=0.
- Reset has priority over start.
- Latency from the start edge to the edge that raises done: 1 cycle for n==0, otherwise 1 + ceil(n/STEP) cycles.
- busy rises on the edge that accepts a start with n>0 and falls on the same edge that raises done.
- done is high for exactly one cycle.
- A new start may be presented in the cycle done is high (busy=0 then), giving back-to-back operations with no gap.
- With n==0, back-to-back starts produce consecutive done pulses every cycle.
- out_data changes only on edges where done rises, or on reset.

## Test plan
- Defaults: in_data=16'h8001, ext_mode=01, sh_op=00, start for one cycle -> next cycle done=1, out_data=32'hFFFF8001, busy never high.
- Same in_data, ext_mode=00 -> out_data=32'h00008001. ext_mode=10 with in_data=16'h1234 -> 32'h12340000. ext_mode=11 with 16'h0001 -> 32'hFFFF0001.
- in_data=16'h8000, ext_mode=01, sh_op=11 (SRA), shamt=4, STEP=1 -> busy high 4 cycles, done on the 5th edge after start, out_data=32'hFFFFF800. Same input with SRL -> 32'h0FFFF800.
- STEP=4, in_data=16'h0003, ext_mode=00, SLL, shamt=31 -> done 1+8=9 cycles after start, out_data=32'h80000000. A second start during busy is ignored and the result is unchanged.
- Start with SLL, shamt=10, then rst_n=0 on the 3rd cycle of SHIFT -> busy=0, done never pulses, out_data=0. A subsequent start with shamt=0 works with 1-cycle latency.
- start in the done cycle of a prior op: SLL 1 of 16'h0001 (ext 00) followed immediately by sh_op=00 of 16'h7FFF -> done pulses on consecutive results 32'h00000002 then 32'h00007FFF.
